// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: fetches an instruction on run and sequences the ALU datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN makes illegal opcodes trap into a sticky HALT state.
module proc_control_fsm #(
  parameter int NREG = 8,
  parameter int IW   = 9
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic [IW-1:0]   din,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            dinout,
  output logic            ain,
  output logic            gin,
  output logic            gout,
  output logic [1:0]      ALU_mode,
  output logic            done,
  output logic            illegal,
  output logic [2:0]      dbg_state
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [2:0]    opcode;
  logic [RW-1:0] rx, ry;
  logic [NREG-1:0] rx_oh, ry_oh;
  logic [1:0]    mode_dec;

  assign opcode = ir_q[IW-1:IW-3];
  assign rx     = ir_q[2*RW-1:RW];
  assign ry     = ir_q[RW-1:0];
  assign rx_oh  = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign ry_oh  = {{(NREG-1){1'b0}}, 1'b1} << ry;
  assign mode_dec = (opcode == OP_SUB) ? 2'b01 :
                    (opcode == OP_XOR) ? 2'b10 : 2'b00;
  assign dbg_state = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Handshake: run is a level start request sampled only in T0 (the fetch cycle);
  // done pulses for exactly the last cycle of each instruction, so a run held high
  // across done starts the next fetch on the following cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= T0;
      ir_q      <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    rin      = '0;
    rout     = '0;
    dinout   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    ALU_mode = 2'b00;
    done     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = din;
          state_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rout    = ry_oh;
            rin     = rx_oh;
            done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            dinout  = 1'b1;
            rin     = rx_oh;
            done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            rout     = rx_oh;
            ain      = 1'b1;
            ALU_mode = mode_dec;
            state_d  = T2;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = HALT;
`else
            done    = 1'b1;
            state_d = T0;
`endif
          end
        endcase
      end
      // T2/T3 are only reachable from an ALU opcode, so mode_dec is always meaningful here.
      T2: begin
        rout     = ry_oh;
        gin      = 1'b1;
        ALU_mode = mode_dec;
        state_d  = T3;
      end
      T3: begin
        gout     = 1'b1;
        rin      = rx_oh;
        done     = 1'b1;
        ALU_mode = mode_dec;
        state_d  = T0;
      end
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm with a small register-file/ALU model on the bus.
module tb_proc_control_fsm;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       run    = 1'b0;
  logic [8:0] din    = '0;
  logic [7:0] rin, rout;
  logic       dinout, ain, gin, gout, done, illegal;
  logic [1:0] alu_mode;
  logic [2:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int rin_pulses  = 0;

  localparam logic [2:0] S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3, S_HALT = 3'd4;

  proc_control_fsm #(.NREG(8), .IW(9)) dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din),
    .rin(rin), .rout(rout), .dinout(dinout), .ain(ain), .gin(gin), .gout(gout),
    .ALU_mode(alu_mode), .done(done), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] ri, input logic [7:0] ro,
                                     input logic di, input logic a, input logic g,
                                     input logic go, input logic [1:0] m,
                                     input logic dn, input logic il);
    return {8'b0, ri, ro, di, a, g, go, m, dn, il};
  endfunction

  wire [31:0] obs_outs = {8'b0, rin, rout, dinout, ain, gin, gout, alu_mode, done, illegal};
  localparam logic [31:0] ZERO = 32'd0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic [31:0] exp);
    check_eq({tag, "_state"}, {29'b0, dbg_state}, {29'b0, st});
    check_eq(tag, obs_outs, exp);
  endtask

  // Register file, A and G modelled from the strobes; updates at negedge when all inputs are settled.
  logic [8:0] rf [8];
  logic [8:0] a_r, g_r;
  always @(negedge clk) begin : datapath
    logic [8:0] bus;
    bus = '0;
    if (dinout) bus = din;
    else if (gout) bus = g_r;
    else for (int i = 0; i < 8; i++) if (rout[i]) bus = rf[i];
    for (int i = 0; i < 8; i++) if (rin[i]) rf[i] <= bus;
    if (ain) a_r <= bus;
    if (gin) begin
      case (alu_mode)
        2'b00:   g_r <= a_r + bus;
        2'b01:   g_r <= a_r - bus;
        default: g_r <= a_r ^ bus;
      endcase
    end
  end

  always @(negedge clk) begin : bus_monitor
    check_eq("bus_excl", {31'b0, ($countones({rout, dinout, gout}) <= 1)}, 32'd1);
    check_eq("rin_onehot0", {31'b0, ($countones(rin) <= 1)}, 32'd1);
    if (rin != 8'h00) rin_pulses++;
  end

  initial begin
    int pulses_before;
    // 1: reset, run held high is ignored
    #2 resetn = 1'b0;
    run = 1'b1;
    din = 9'b001_000_000;
    #1 chk_st("rst_async", S_T0, ZERO);
    cyc(); chk_st("rst_hold1", S_T0, ZERO);
    cyc(); chk_st("rst_hold2", S_T0, ZERO);
    resetn = 1'b1;
    run = 1'b0;
    cyc(); chk_st("rst_release", S_T0, ZERO);

    // 2: mvi R0,2 then mvi R1,3
    din = 9'b001_000_000; run = 1'b1;
    cyc(); chk_st("mvi_r0_t1", S_T1, pk(8'h01, 8'h00, 1, 0, 0, 0, 2'b00, 1, 0));
    din = 9'd2; run = 1'b0;
    cyc(); chk_st("mvi_r0_t0", S_T0, ZERO);
    din = 9'b001_001_000; run = 1'b1;
    cyc(); chk_st("mvi_r1_t1", S_T1, pk(8'h02, 8'h00, 1, 0, 0, 0, 2'b00, 1, 0));
    din = 9'd3; run = 1'b0;
    cyc(); chk_st("mvi_r1_t0", S_T0, ZERO);
    check_eq("r0_loaded", {23'b0, rf[0]}, 32'd2);
    check_eq("r1_loaded", {23'b0, rf[1]}, 32'd3);

    // 3: add R0,R1
    din = 9'b010_000_001; run = 1'b1;
    cyc(); chk_st("add_t1", S_T1, pk(8'h00, 8'h01, 0, 1, 0, 0, 2'b00, 0, 0));
    din = '0; run = 1'b0;
    cyc(); chk_st("add_t2", S_T2, pk(8'h00, 8'h02, 0, 0, 1, 0, 2'b00, 0, 0));
    cyc(); chk_st("add_t3", S_T3, pk(8'h01, 8'h00, 0, 0, 0, 1, 2'b00, 1, 0));
    cyc(); chk_st("add_t0", S_T0, ZERO);
    check_eq("add_r0_sum", {23'b0, rf[0]}, 32'd5);

    // 4: sub R2,R3 then xor R4,R5 back-to-back with run held
    din = 9'b011_010_011; run = 1'b1;
    cyc(); chk_st("sub_t1", S_T1, pk(8'h00, 8'h04, 0, 1, 0, 0, 2'b01, 0, 0));
    cyc(); chk_st("sub_t2", S_T2, pk(8'h00, 8'h08, 0, 0, 1, 0, 2'b01, 0, 0));
    cyc(); chk_st("sub_t3", S_T3, pk(8'h04, 8'h00, 0, 0, 0, 1, 2'b01, 1, 0));
    din = 9'b100_100_101;
    cyc(); chk_st("b2b_fetch", S_T0, ZERO);
    cyc(); chk_st("xor_t1", S_T1, pk(8'h00, 8'h10, 0, 1, 0, 0, 2'b10, 0, 0));
    cyc(); chk_st("xor_t2", S_T2, pk(8'h00, 8'h20, 0, 0, 1, 0, 2'b10, 0, 0));
    run = 1'b0;
    cyc(); chk_st("xor_t3", S_T3, pk(8'h10, 8'h00, 0, 0, 0, 1, 2'b10, 1, 0));
    cyc(); chk_st("xor_t0", S_T0, ZERO);
    cyc(); chk_st("idle_stay", S_T0, ZERO);

    // 5: reset asserted during T2 of add
    din = 9'b010_000_001; run = 1'b1;
    cyc(); chk_st("abort_t1", S_T1, pk(8'h00, 8'h01, 0, 1, 0, 0, 2'b00, 0, 0));
    run = 1'b0;
    cyc(); chk_st("abort_t2", S_T2, pk(8'h00, 8'h02, 0, 0, 1, 0, 2'b00, 0, 0));
    pulses_before = rin_pulses;
    resetn = 1'b0;
    #1 chk_st("abort_async", S_T0, ZERO);
    cyc(); chk_st("abort_hold", S_T0, ZERO);
    resetn = 1'b1;
    cyc(); chk_st("abort_release", S_T0, ZERO);
    check_eq("abort_no_rin", rin_pulses - pulses_before, 32'd0);

    // mv R6,R0 and mv R3,R3 after restart
    din = 9'b000_110_000; run = 1'b1;
    cyc(); chk_st("mv_t1", S_T1, pk(8'h40, 8'h01, 0, 0, 0, 0, 2'b00, 1, 0));
    run = 1'b0;
    cyc(); chk_st("mv_t0", S_T0, ZERO);
    check_eq("mv_r6", {23'b0, rf[6]}, 32'd5);
    din = 9'b000_011_011; run = 1'b1;
    cyc(); chk_st("mv_same_t1", S_T1, pk(8'h08, 8'h08, 0, 0, 0, 0, 2'b00, 1, 0));
    run = 1'b0;
    cyc(); chk_st("mv_same_t0", S_T0, ZERO);

    // 6: illegal opcode 111
    din = 9'b111_010_011; run = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    cyc(); chk_st("ill_t1", S_T1, ZERO);
    din = 9'b001_111_000;
    cyc(); chk_st("ill_halt", S_HALT, pk(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1));
    cyc(); chk_st("ill_halt_run", S_HALT, pk(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1));
    cyc(); chk_st("ill_halt_run2", S_HALT, pk(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1));
    run = 1'b0;
    resetn = 1'b0;
    #1 chk_st("ill_reset", S_T0, ZERO);
    cyc();
    resetn = 1'b1;
    cyc(); chk_st("ill_release", S_T0, ZERO);
`else
    cyc(); chk_st("nop_t1", S_T1, pk(8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0));
    din = 9'b001_111_000;
    cyc(); chk_st("nop_t0", S_T0, ZERO);
    cyc(); chk_st("nop_next_t1", S_T1, pk(8'h80, 8'h00, 1, 0, 0, 0, 2'b00, 1, 0));
    din = 9'd9; run = 1'b0;
    cyc(); chk_st("nop_next_t0", S_T0, ZERO);
    check_eq("nop_next_r7", {23'b0, rf[7]}, 32'd9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
